// File: rtl/key_event_pkg.sv
// Shared types and defaults for the key event decoder.
// Holds the FSM state encodings and the default timing constants.
package key_event_pkg;

  typedef enum logic [2:0] {
    KE_IDLE   = 3'd0,
    KE_PRESS1 = 3'd1,
    KE_WAIT2  = 3'd2,
    KE_PRESS2 = 3'd3,
    KE_LONG   = 3'd4
  } ke_state_t;

  localparam int KE_LONG_CNT   = 8;
  localparam int KE_DCLICK_WIN = 6;
  localparam int KE_CNT_W      = 4;

endpackage

// File: rtl/key_event_decoder_edge_detect.sv
// Rise/fall detector on a clean level signal.
// Ports: clk, rst_n, d (level), rise/fall (combinational vs registered d).
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into press/release/click/long events.
// Ports: clk, rst_n, btn in; registered pulse outputs plus held level.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int LONG_CNT   = KE_LONG_CNT,
  parameter int DCLICK_WIN = KE_DCLICK_WIN,
  parameter int CNT_W      = KE_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(DCLICK_WIN - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic rise;
  logic fall;

  edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn),
    .rise  (rise),
    .fall  (fall)
  );

  ke_state_t        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             sc_d, dc_d, lp_d;

  // Edges take priority over timer expiry in every state.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sc_d    = 1'b0;
    dc_d    = 1'b0;
    lp_d    = 1'b0;
    case (state)
      KE_IDLE: begin
        if (rise) begin
          state_d = KE_PRESS1;
          cnt_d   = '0;
        end
      end
      KE_PRESS1: begin
        if (fall) begin
          state_d = KE_WAIT2;
          cnt_d   = '0;
        end else if (cnt == LONG_LAST) begin
          state_d = KE_LONG;
          lp_d    = 1'b1;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      KE_WAIT2: begin
        if (rise) begin
          state_d = KE_PRESS2;
        end else if (cnt == WIN_LAST) begin
          state_d = KE_IDLE;
          sc_d    = 1'b1;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      KE_PRESS2: begin
        if (fall) begin
          state_d = KE_IDLE;
          dc_d    = 1'b1;
        end
      end
      KE_LONG: begin
        if (fall) state_d = KE_IDLE;
      end
      default: begin
        state_d = KE_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= KE_IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_click   <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      press_pulse   <= rise;
      release_pulse <= fall;
      short_click   <= sc_d;
      double_click  <= dc_d;
      long_press    <= lp_d;
      held          <= (state_d == KE_LONG);
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with a timing-based event model.
// Model compares every cycle; directed blocks pin counts and latencies.
module tb_key_event_decoder;

  localparam int LONG_CNT   = 8;
  localparam int DCLICK_WIN = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  logic press_pulse, release_pulse, short_click;
  logic double_click, long_press, held;

  key_event_decoder #(
    .LONG_CNT   (LONG_CNT),
    .DCLICK_WIN (DCLICK_WIN),
    .CNT_W      (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn           (btn),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_click   (short_click),
    .double_click  (double_click),
    .long_press    (long_press),
    .held          (held)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Sampled view of each rising edge.
  int   cyc = 0;
  logic s_btn = 1'b0;
  logic last_rst = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    s_btn    <= btn;
    last_rst <= rst_n;
  end

  // Model: what the key is doing, tracked by elapsed-time stamps.
  typedef enum int { M_NONE, M_FIRST, M_GAP, M_SECOND, M_HOLD } mode_t;
  mode_t mode = M_NONE;
  int    now = 0;
  int    t_mark = 0;
  logic  prev = 1'b0;
  logic  e_pp, e_rp, e_sc, e_dc, e_lp, e_hd;

  // DUT event log for the directed literal checks.
  int n_press, n_rel, n_sc, n_dc, n_lp;
  int c_press, c_rel, c_sc, c_lp;

  task automatic clr_log();
    n_press = 0; n_rel = 0; n_sc = 0; n_dc = 0; n_lp = 0;
    c_press = 0; c_rel = 0; c_sc = 0; c_lp = 0;
  endtask

  always @(negedge clk) begin
    logic r, f;
    e_pp = 0; e_rp = 0; e_sc = 0; e_dc = 0; e_lp = 0;
    if (!rst_n || !last_rst) begin
      mode = M_NONE;
      prev = 1'b0;
    end else begin
      now++;
      r = s_btn & ~prev;
      f = ~s_btn & prev;
      prev = s_btn;
      e_pp = r;
      e_rp = f;
      case (mode)
        M_NONE:   if (r) begin mode = M_FIRST; t_mark = now; end
        M_FIRST:
          if (f) begin
            mode = M_GAP; t_mark = now;
          end else if (now - t_mark == LONG_CNT) begin
            e_lp = 1; mode = M_HOLD;
          end
        M_GAP:
          if (r) mode = M_SECOND;
          else if (now - t_mark == DCLICK_WIN) begin
            e_sc = 1; mode = M_NONE;
          end
        M_SECOND: if (f) begin e_dc = 1; mode = M_NONE; end
        M_HOLD:   if (f) mode = M_NONE;
        default:  mode = M_NONE;
      endcase
    end
    e_hd = (mode == M_HOLD);
    chk("press_pulse", int'(press_pulse), int'(e_pp));
    chk("release_pulse", int'(release_pulse), int'(e_rp));
    chk("short_click", int'(short_click), int'(e_sc));
    chk("double_click", int'(double_click), int'(e_dc));
    chk("long_press", int'(long_press), int'(e_lp));
    chk("held", int'(held), int'(e_hd));
    if (press_pulse)   begin n_press++; c_press = cyc; end
    if (release_pulse) begin n_rel++;   c_rel = cyc;   end
    if (short_click)   begin n_sc++;    c_sc = cyc;    end
    if (double_click)  n_dc++;
    if (long_press)    begin n_lp++;    c_lp = cyc;    end
  end

  task automatic drive(logic v, int n);
    btn = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic zeros(string tag);
    chk({tag, "_pp"}, int'(press_pulse), 0);
    chk({tag, "_rp"}, int'(release_pulse), 0);
    chk({tag, "_sc"}, int'(short_click), 0);
    chk({tag, "_dc"}, int'(double_click), 0);
    chk({tag, "_lp"}, int'(long_press), 0);
    chk({tag, "_held"}, int'(held), 0);
  endtask

  task automatic do_reset(logic b, string tag);
    rst_n = 1'b0;
    btn = b;
    #1;
    zeros(tag);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int r0;
    clr_log();
    do_reset(1'b0, "por");

    // Single click.
    clr_log();
    drive(1, 3); drive(0, 12);
    chk("sc_n_press", n_press, 1);
    chk("sc_n_rel", n_rel, 1);
    chk("sc_n_sc", n_sc, 1);
    chk("sc_lat", c_sc - c_rel, 6);
    chk("sc_n_dc", n_dc, 0);
    chk("sc_n_lp", n_lp, 0);

    // Double click.
    clr_log();
    drive(1, 2); drive(0, 3); drive(1, 2); drive(0, 12);
    chk("dc_n_press", n_press, 2);
    chk("dc_n_rel", n_rel, 2);
    chk("dc_n_dc", n_dc, 1);
    chk("dc_n_sc", n_sc, 0);

    // Long press.
    clr_log();
    drive(1, 20);
    chk("lp_held_on", int'(held), 1);
    drive(0, 12);
    chk("lp_n_lp", n_lp, 1);
    chk("lp_lat", c_lp - c_press, 8);
    chk("lp_n_sc", n_sc, 0);
    chk("lp_n_dc", n_dc, 0);
    chk("lp_held_off", int'(held), 0);

    // Release seen exactly when the long timer would expire.
    clr_log();
    drive(1, 8); drive(0, 12);
    chk("bl_n_lp", n_lp, 0);
    chk("bl_n_sc", n_sc, 1);

    // One cycle longer does reach long press.
    clr_log();
    drive(1, 9); drive(0, 12);
    chk("bl9_n_lp", n_lp, 1);
    chk("bl9_n_sc", n_sc, 0);

    // Re-press sampled on the window expiry cycle.
    clr_log();
    drive(1, 2); drive(0, 6); drive(1, 2); drive(0, 12);
    chk("bw_n_dc", n_dc, 1);
    chk("bw_n_sc", n_sc, 0);

    // Re-press one cycle too late: two short clicks.
    clr_log();
    drive(1, 2); drive(0, 7); drive(1, 2); drive(0, 12);
    chk("bw7_n_sc", n_sc, 2);
    chk("bw7_n_dc", n_dc, 0);

    // Reset while waiting for a second press.
    drive(1, 2); drive(0, 2);
    do_reset(1'b0, "rw2");
    clr_log();
    drive(0, 12);
    chk("rw2_events", n_press + n_rel + n_sc + n_dc + n_lp, 0);

    // Reset while held.
    drive(1, 12);
    chk("rl_held_on", int'(held), 1);
    do_reset(1'b0, "rlg");
    clr_log();
    drive(0, 12);
    chk("rlg_events", n_press + n_rel + n_sc + n_dc + n_lp, 0);

    // Reset released with the key already down.
    rst_n = 1'b0;
    btn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr_log();
    r0 = cyc;
    rst_n = 1'b1;
    drive(1, 3); drive(0, 12);
    chk("rh_n_press", n_press, 1);
    chk("rh_press_cyc", c_press - r0, 1);
    chk("rh_n_sc", n_sc, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
